// File: rtl/timer_pkg.sv
// Shared encodings for the count/timer controller: FSM states and run-mode constants.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/count_timer_ctrl_if.sv
// Control/config/status bundle between the software-facing FSM layer and the timer controller.
interface count_timer_ctrl_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [WIDTH-1:0]      cfg_limit;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic                  cfg_mode;
  logic                  start;
  logic                  pause;
  logic                  stop;
  logic [WIDTH-1:0]      count;
  logic                  running;
  logic                  tick;
  logic                  done;

  modport master (
    output cfg_valid, cfg_limit, cfg_prescale, cfg_mode, start, pause, stop,
    input  cfg_ready, count, running, tick, done
  );

  modport slave (
    input  cfg_valid, cfg_limit, cfg_prescale, cfg_mode, start, pause, stop,
    output cfg_ready, count, running, tick, done
  );

endinterface

// File: rtl/up_count_core.sv
// Plain synchronous up counter with clear-over-enable priority; wraps modulo 2^WIDTH.
module up_count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (clr)  q <= '0;
    else if (en)   q <= q + ONE;
  end

endmodule

// File: rtl/count_timer_ctrl.sv
// Sequencing controller for an up-count datapath: config latch, prescaler, terminal compare,
// start/pause/stop FSM, and registered tick/done/running/ready status.
module count_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  count_timer_ctrl_if.slave bus
);

  state_t                state, state_nx;
  logic [WIDTH-1:0]      lim_r;
  logic [PRESCALE_W-1:0] pre_r;
  logic                  mode_r;
  logic [WIDTH-1:0]      cnt_q;
  logic [PRESCALE_W-1:0] pre_q;

  logic cnt_clr, cnt_en, pre_clr, pre_en, cfg_load, tick_nx, en;
  logic tick_r, done_r, running_r, ready_r;

  up_count_core #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (cnt_q)
  );

  up_count_core #(.WIDTH(PRESCALE_W)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .q     (pre_q)
  );

  // Prescaler terminal: one count step every (prescale+1) RUN cycles
  assign en = (state == RUN) && (pre_q == pre_r);

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    pre_clr  = 1'b0;
    pre_en   = 1'b0;
    cfg_load = 1'b0;
    tick_nx  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.stop) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
          pre_clr  = 1'b1;
        end else if (bus.cfg_valid) begin
          cfg_load = 1'b1;
          state_nx = IDLE;
          cnt_clr  = 1'b1;
          pre_clr  = 1'b1;
        end else if (bus.start) begin
          state_nx = RUN;
          cnt_clr  = 1'b1;
          pre_clr  = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
          pre_clr  = 1'b1;
        end else if (bus.start) begin
          cnt_clr = 1'b1;
          pre_clr = 1'b1;
        end else if (bus.pause) begin
          state_nx = HOLD;
        end else if (en) begin
          pre_clr = 1'b1;
          if (cnt_q == lim_r) begin
            // Terminal event: periodic wraps, one-shot parks at the limit
            tick_nx = 1'b1;
            if (mode_r == MODE_PERIODIC) cnt_clr  = 1'b1;
            else                         state_nx = DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end else begin
          pre_en = 1'b1;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
          pre_clr  = 1'b1;
        end else if (bus.start) begin
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lim_r     <= '1;
      pre_r     <= '0;
      mode_r    <= MODE_PERIODIC;
      tick_r    <= 1'b0;
      done_r    <= 1'b0;
      running_r <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state <= state_nx;
      if (cfg_load) begin
        lim_r  <= bus.cfg_limit;
        pre_r  <= bus.cfg_prescale;
        mode_r <= bus.cfg_mode;
      end
      tick_r    <= tick_nx;
      done_r    <= (state_nx == DONE);
      running_r <= (state_nx == RUN);
      ready_r   <= (state_nx == IDLE) || (state_nx == DONE);
    end
  end

  assign bus.count     = cnt_q;
  assign bus.running   = running_r;
  assign bus.tick      = tick_r;
  assign bus.done      = done_r;
  assign bus.cfg_ready = ready_r;

endmodule
